video_clken_nco: RTL

Multi-channel numerically-controlled clock-enable generator for the VGA subsystem. It runs from the single reference clock and produces NUM_CH independent pixel/strobe enables at programmable fractional rates of that clock. Each channel supports run-time retuning at a phase-continuous boundary and has a per-channel locked indicator. Downstream video timing logic uses it in place of a fixed analog PLL output when a mode change must happen without reconfiguring the PLL.

---
 rtl/video_clken_pkg.sv | 31 +++
 rtl/video_nco_channel.sv | 83 ++++++++
 rtl/video_clken_nco.sv | 96 +++++++++
 3 files changed

// File: rtl/video_clken_pkg.sv
// video_clken_pkg
// Shared defaults, configuration request type and a frequency-to-increment
// helper for the video clock-enable NCO.
package video_clken_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int ACC_W_DEF  = 32;
    localparam int CH_W       = 3;
    // The request slot is sized for the widest legal accumulator so the
    // same struct serves every ACC_W.
    localparam int INC_MAX_W  = 48;

    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic                 en;
        logic [INC_MAX_W-1:0] inc;
    } cfg_req_t;

    // inc = round(f_out / f_ref * 2^acc_w). Done in real arithmetic so
    // wide accumulators do not overflow a 64-bit intermediate.
    function automatic logic [INC_MAX_W-1:0] freq_to_inc(
        input longint unsigned f_out_hz,
        input longint unsigned f_ref_hz,
        input int              acc_w
    );
        real r;
        r = (real'(f_out_hz) / real'(f_ref_hz)) * (2.0 ** acc_w);
        return INC_MAX_W'(longint'(r));
    endfunction

endpackage

// File: rtl/video_nco_channel.sv
// video_nco_channel
// One NCO clock-enable channel: phase accumulator, increment, enable,
// registered carry output and lock counter.
// Ports:
//   refclk, rst_n      clock, async active-low reset
//   apply              load the pending request this cycle
//   apply_en/apply_inc request contents
//   clken              registered carry (one-cycle enable pulse)
//   carry_next         carry being generated this cycle
//   locked             LOCK_PULSES pulses seen since last apply
//   idle               channel disabled or inc==0 (request may apply at once)
module video_nco_channel #(
    parameter int               ACC_W       = 32,
    parameter int               LOCK_PULSES = 16,
    parameter logic [ACC_W-1:0] INC_RST     = '0,
    parameter logic             EN_RST      = 1'b1
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             apply,
    input  logic             apply_en,
    input  logic [ACC_W-1:0] apply_inc,
    output logic             clken,
    output logic             carry_next,
    output logic             locked,
    output logic             idle
);

    localparam int                LCNT_W   = $clog2(LOCK_PULSES + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_PULSES);

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  inc_q;
    logic              en_q;
    logic [LCNT_W-1:0] lcnt_q;
    logic [LCNT_W-1:0] lcnt_d;
    logic [ACC_W:0]    sum;

    assign sum        = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry_next = en_q & sum[ACC_W];
    assign idle       = ~en_q | (inc_q == '0);

    // A pulse coinciding with apply is not counted: the counter restarts.
    always_comb begin
        lcnt_d = lcnt_q;
        if (apply)
            lcnt_d = '0;
        else if (carry_next && (lcnt_q != LCNT_MAX))
            lcnt_d = lcnt_q + 1'b1;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            inc_q  <= INC_RST;
            en_q   <= EN_RST;
            clken  <= 1'b0;
            lcnt_q <= '0;
            locked <= 1'b0;
        end else begin
            clken  <= carry_next & ~(apply & ~apply_en);
            lcnt_q <= lcnt_d;
            locked <= (lcnt_d == LCNT_MAX);
            if (apply && !apply_en) begin
                en_q  <= 1'b0;
                acc_q <= '0;
            end else if (apply && carry_next) begin
                // Phase-continuous retune: keep the residual, old inc used
                // for this addition, new inc from the next cycle.
                acc_q <= sum[ACC_W-1:0];
                inc_q <= apply_inc;
            end else if (apply) begin
                if (!en_q)
                    acc_q <= '0;
                en_q  <= 1'b1;
                inc_q <= apply_inc;
            end else if (en_q) begin
                acc_q <= sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/video_clken_nco.sv
// video_clken_nco
// Multi-channel numerically-controlled clock-enable generator. Owns the
// single-entry configuration slot, the valid/ready handshake and the
// decision of when a pending request is applied to its channel.
// Ports:
//   refclk, rst_n  clock, async active-low reset
//   cfg_valid/cfg_ready  request handshake (ready low while a retune pends)
//   cfg_ch, cfg_en, cfg_inc  request contents
//   clken          per-channel one-cycle enable pulses
//   locked         per-channel stable-rate flag
module video_clken_nco
    import video_clken_pkg::*;
#(
    parameter int                      NUM_CH      = NUM_CH_DEF,
    parameter int                      ACC_W       = ACC_W_DEF,
    parameter int                      LOCK_PULSES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] INC_RST     = {32'hA8F5C28F, 32'h80000000, 32'h80000000},
    parameter logic [NUM_CH-1:0]       EN_RST      = '1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_en,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] clken,
    output logic [NUM_CH-1:0] locked
);

    cfg_req_t          pend_q;
    logic              pend_valid_q;
    logic              pend_valid_d;
    logic              ready_q;
    logic              xfer;
    logic              ch_ok;
    logic              apply_now;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] carry_next;
    logic [NUM_CH-1:0] idle;
    logic [7:0]        carry_all;
    logic [7:0]        idle_all;
    logic              unused_inc_bits;

    assign cfg_ready = ready_q;
    assign xfer      = cfg_valid & ready_q;
    // Out-of-range channels complete the handshake but never occupy the slot.
    assign ch_ok     = int'(cfg_ch) < NUM_CH;

    assign carry_all = 8'(carry_next);
    assign idle_all  = 8'(idle);

    // Immediate apply when the channel is not accumulating or is being
    // disabled; otherwise wait for the channel's carry cycle.
    assign apply_now = pend_valid_q &
                       (idle_all[pend_q.ch] | ~pend_q.en | carry_all[pend_q.ch]);

    assign pend_valid_d = pend_valid_q ? ~apply_now : (xfer & ch_ok);

    assign unused_inc_bits = ^pend_q.inc;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            ready_q      <= 1'b1;
        end else begin
            pend_valid_q <= pend_valid_d;
            ready_q      <= ~pend_valid_d;
            if (xfer && ch_ok)
                pend_q <= '{ch: cfg_ch, en: cfg_en, inc: INC_MAX_W'(cfg_inc)};
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign apply[c] = apply_now & (pend_q.ch == CH_W'(c));

        video_nco_channel #(
            .ACC_W       (ACC_W),
            .LOCK_PULSES (LOCK_PULSES),
            .INC_RST     (INC_RST[c*ACC_W +: ACC_W]),
            .EN_RST      (EN_RST[c])
        ) u_ch (
            .refclk     (refclk),
            .rst_n      (rst_n),
            .apply      (apply[c]),
            .apply_en   (pend_q.en),
            .apply_inc  (pend_q.inc[ACC_W-1:0]),
            .clken      (clken[c]),
            .carry_next (carry_next[c]),
            .locked     (locked[c]),
            .idle       (idle[c])
        );
    end

endmodule
